// File: rtl/clb_config_loader_if.sv
// Serial configuration bit stream handshake between a bit source and the CLB loader.
interface clb_config_loader_if;
  logic cfg_bit_i;
  logic cfg_valid_i;
  logic cfg_ready_o;

  modport master (output cfg_bit_i, output cfg_valid_i, input cfg_ready_o);
  modport slave  (input cfg_bit_i, input cfg_valid_i, output cfg_ready_o);
endinterface

// File: rtl/clb_config_loader.sv
// Loads a parity-protected serial frame of NUM_CLB config words into a shadow
// store and commits all words to confi_o atomically once every record checks out.
module clb_config_loader #(
  parameter int NUM_CLB = 4,
  parameter int CFG_W   = 13
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     start_i,
  clb_config_loader_if.slave       cfg,
  output logic [NUM_CLB*CFG_W-1:0] confi_o,
  output logic                     busy_o,
  output logic                     done_o,
  output logic                     err_o
);

  localparam int BCW = $clog2(CFG_W + 1);
  localparam int WCW = (NUM_CLB > 1) ? $clog2(NUM_CLB) : 1;

  typedef enum logic [1:0] {IDLE, SHIFT, COMMIT, ERROR} state_e;

  state_e                          state_q, state_d;
  logic [BCW-1:0]                  bit_cnt_q, bit_cnt_d;
  logic [WCW-1:0]                  word_cnt_q, word_cnt_d;
  logic [CFG_W-1:0]                sreg_q, sreg_d;
  logic [NUM_CLB-1:0][CFG_W-1:0]   shadow_q, shadow_d;
  logic [NUM_CLB-1:0][CFG_W-1:0]   confi_q, confi_d;
  logic                            err_q, err_d;
  logic                            accept;

  assign cfg.cfg_ready_o = (state_q == SHIFT);
  assign busy_o          = (state_q == SHIFT) || (state_q == COMMIT);
  assign done_o          = (state_q == COMMIT);
  assign err_o           = err_q;
  assign confi_o         = confi_q;

  // A start pulse in SHIFT wins over a bit offered in the same cycle.
  assign accept = cfg.cfg_valid_i && cfg.cfg_ready_o && !start_i;

  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    word_cnt_d = word_cnt_q;
    sreg_d     = sreg_q;
    shadow_d   = shadow_q;
    confi_d    = confi_q;
    err_d      = err_q;
    case (state_q)
      IDLE, ERROR: begin
        if (start_i) begin
          state_d    = SHIFT;
          err_d      = 1'b0;
          bit_cnt_d  = '0;
          word_cnt_d = '0;
          sreg_d     = '0;
        end
      end
      SHIFT: begin
        if (start_i) begin
          bit_cnt_d  = '0;
          word_cnt_d = '0;
          sreg_d     = '0;
        end else if (accept) begin
          if (bit_cnt_q != BCW'(CFG_W)) begin
            // LSB arrives first, so shift right and insert at the top.
            sreg_d            = sreg_q >> 1;
            sreg_d[CFG_W-1]   = cfg.cfg_bit_i;
            bit_cnt_d         = bit_cnt_q + BCW'(1);
          end else begin
            bit_cnt_d = '0;
            sreg_d    = '0;
            if (^{sreg_q, cfg.cfg_bit_i}) begin
              state_d    = ERROR;
              err_d      = 1'b1;
              shadow_d   = '0;
              word_cnt_d = '0;
            end else begin
              shadow_d[word_cnt_q] = sreg_q;
              if (word_cnt_q == WCW'(NUM_CLB - 1)) begin
                // Commit the whole frame on the same edge the last word lands,
                // so confi_o and done_o appear together one cycle later.
                word_cnt_d = '0;
                state_d    = COMMIT;
                confi_d    = shadow_d;
              end else begin
                word_cnt_d = word_cnt_q + WCW'(1);
              end
            end
          end
        end
      end
      COMMIT:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      bit_cnt_q  <= '0;
      word_cnt_q <= '0;
      sreg_q     <= '0;
      shadow_q   <= '0;
      confi_q    <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      word_cnt_q <= word_cnt_d;
      sreg_q     <= sreg_d;
      shadow_q   <= shadow_d;
      confi_q    <= confi_d;
      err_q      <= err_d;
    end
  end

endmodule

// File: tb/tb_clb_config_loader.sv
// Randomized scoreboard bench for clb_config_loader: frames built from words,
// expected commits queued at stimulus time and checked by a done_o monitor.
module tb_clb_config_loader;
  localparam int NUM_CLB = 4;
  localparam int CFG_W   = 13;
  localparam int W       = NUM_CLB * CFG_W;
  localparam int REC     = CFG_W + 1;
  localparam int TOTAL   = NUM_CLB * REC;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] confi;
  logic         busy, done, err;

  clb_config_loader_if cfg_if ();

  clb_config_loader #(.NUM_CLB(NUM_CLB), .CFG_W(CFG_W)) dut (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .start_i (start),
    .cfg     (cfg_if.slave),
    .confi_o (confi),
    .busy_o  (busy),
    .done_o  (done),
    .err_o   (err)
  );

  always #5 clk = ~clk;

  int           tests = 0;
  int           fails = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] model_confi = '0;
  logic [CFG_W-1:0] frame_w [NUM_CLB];
  bit           gaps = 1'b0;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [W-1:0] packed_frame();
    logic [W-1:0] r = '0;
    for (int k = 0; k < NUM_CLB; k++) r[k*CFG_W +: CFG_W] = frame_w[k];
    return r;
  endfunction

  // Monitor: every done_o cycle must match the oldest queued expectation.
  always @(negedge clk) begin
    if (rst_n && done) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_done: got done=1 expected none, confi=%h", confi);
      end else begin
        chk("commit_confi", confi, exp_q.pop_front());
      end
    end
  end

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic send_bit(input logic b);
    bit acc = 1'b0;
    int n = 0;
    while (!acc && n < 200) begin
      cfg_if.cfg_valid_i = gaps ? ($urandom_range(0, 1) == 1) : 1'b1;
      cfg_if.cfg_bit_i   = b;
      @(negedge clk);
      acc = cfg_if.cfg_valid_i && cfg_if.cfg_ready_o;
      @(posedge clk); #1;
      n++;
    end
    cfg_if.cfg_valid_i = 1'b0;
    if (!acc) begin
      tests++;
      fails++;
      $display("FAIL bit_timeout: got no acceptance in %0d cycles expected acceptance", n);
    end
  endtask

  // corrupt_rec < 0 means a good frame; limit < TOTAL sends a truncated frame.
  task automatic send_frame(input int corrupt_rec, input int limit);
    logic [W-1:0] expv = packed_frame();
    bit full_good = (corrupt_rec < 0) && (limit >= TOTAL);
    for (int idx = 0; idx < TOTAL && idx < limit; idx++) begin
      int rec = idx / REC;
      int pos = idx % REC;
      logic b = (pos < CFG_W) ? frame_w[rec][pos] : ^frame_w[rec];
      bit bad = (rec == corrupt_rec) && (pos == CFG_W);
      if (bad) b = ~b;
      if (full_good && idx == TOTAL - 1) begin
        chk("hold_before_commit", confi, model_confi);
        exp_q.push_back(expv);
      end
      send_bit(b);
      if (bad) begin
        chk("err_set", W'(err), W'(1));
        chk("err_busy", W'(busy), W'(0));
        chk("err_confi_hold", confi, model_confi);
        return;
      end
    end
    if (full_good) begin
      chk("done_latency", W'(done), W'(1));
      model_confi = expv;
      @(posedge clk); #1;
      chk("done_one_cycle", W'(done), W'(0));
      chk("busy_after", W'(busy), W'(0));
    end
  endtask

  task automatic rand_frame();
    for (int k = 0; k < NUM_CLB; k++) frame_w[k] = CFG_W'($urandom);
  endtask

  initial begin
    logic [W-1:0] saved;
    logic [CFG_W-1:0] keep [NUM_CLB];
    cfg_if.cfg_valid_i = 1'b0;
    cfg_if.cfg_bit_i   = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_confi", confi, '0);
    chk("rst_busy", W'(busy), W'(0));
    chk("rst_done", W'(done), W'(0));
    chk("rst_err", W'(err), W'(0));
    chk("rst_ready", W'(cfg_if.cfg_ready_o), W'(0));
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Uniform 0x1001 frame
    for (int k = 0; k < NUM_CLB; k++) frame_w[k] = 13'h1001;
    pulse_start();
    chk("start_busy", W'(busy), W'(1));
    chk("start_ready", W'(cfg_if.cfg_ready_o), W'(1));
    send_frame(-1, TOTAL);
    chk("frame_1001", confi, {4{13'h1001}});

    // Only word 0 populated
    frame_w[0] = 13'h0E01;
    for (int k = 1; k < NUM_CLB; k++) frame_w[k] = '0;
    pulse_start();
    send_frame(-1, TOTAL);
    chk("frame_0e01", confi, {39'd0, 13'h0E01});

    // Parity failure on record 2 keeps the previous frame
    rand_frame();
    pulse_start();
    send_frame(-1, TOTAL);
    rand_frame();
    pulse_start();
    send_frame(2, TOTAL);
    @(posedge clk); #1;
    chk("err_sticky", W'(err), W'(1));
    pulse_start();
    chk("err_cleared", W'(err), W'(0));
    rand_frame();
    send_frame(-1, TOTAL);

    // Gappy load equals gap-free load
    rand_frame();
    for (int k = 0; k < NUM_CLB; k++) keep[k] = frame_w[k];
    pulse_start();
    send_frame(-1, TOTAL);
    saved = confi;
    rand_frame();
    pulse_start();
    send_frame(-1, TOTAL);
    for (int k = 0; k < NUM_CLB; k++) frame_w[k] = keep[k];
    gaps = 1'b1;
    pulse_start();
    send_frame(-1, TOTAL);
    gaps = 1'b0;
    chk("gap_equiv", confi, saved);

    // Abort after 20 bits, with a bit offered alongside the restart
    rand_frame();
    pulse_start();
    send_frame(-1, 20);
    cfg_if.cfg_valid_i = 1'b1;
    cfg_if.cfg_bit_i   = 1'b1;
    pulse_start();
    cfg_if.cfg_valid_i = 1'b0;
    rand_frame();
    send_frame(-1, TOTAL);
    chk("abort_second_only", confi, packed_frame());

    // Random frames, random gaps
    for (int t = 0; t < 6; t++) begin
      gaps = ($urandom_range(0, 1) == 1);
      rand_frame();
      pulse_start();
      send_frame(-1, TOTAL);
    end
    gaps = 1'b0;

    // Reset mid-frame after a commit
    rand_frame();
    pulse_start();
    send_frame(-1, 10);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    model_confi = '0;
    chk("midrst_confi", confi, '0);
    chk("midrst_busy", W'(busy), W'(0));
    chk("midrst_err", W'(err), W'(0));
    for (int i = 0; i < 5; i++) begin
      cfg_if.cfg_valid_i = 1'b1;
      cfg_if.cfg_bit_i   = 1'($urandom);
      @(negedge clk);
      chk("midrst_ready", W'(cfg_if.cfg_ready_o), W'(0));
      @(posedge clk); #1;
    end
    cfg_if.cfg_valid_i = 1'b0;
    chk("midrst_confi_after", confi, '0);
    chk("midrst_no_pending", W'(exp_q.size()), W'(0));

    // Loader still works after the mid-frame reset
    rand_frame();
    pulse_start();
    send_frame(-1, TOTAL);
    repeat (2) @(posedge clk);
    #1;
    chk("queue_drained", W'(exp_q.size()), W'(0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
